// File: rtl/mem_arbiter_if.sv
//----------------------------------------------------------------------
// mem_arbiter_if : two requester ports plus the shared memory bus.
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

interface mem_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0;
    logic             we0;
    logic [31:0]      addr0;
    logic [WIDTH-1:0] wdata0;
    logic             gnt0;
    logic             rvalid0;
    logic [WIDTH-1:0] rdata0;

    logic             req1;
    logic             we1;
    logic [31:0]      addr1;
    logic [WIDTH-1:0] wdata1;
    logic             gnt1;
    logic             rvalid1;
    logic [WIDTH-1:0] rdata1;

    logic [31:0]      mem_addr;
    logic [WIDTH-1:0] mem_in;
    logic             mem_we;
    logic [WIDTH-1:0] mem_out;

    // Requesters and the memory model together.
    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_out,
        input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
        input  mem_addr, mem_in, mem_we
    );

    // The arbiter.
    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_out,
        output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
        output mem_addr, mem_in, mem_we
    );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
//----------------------------------------------------------------------
// mem_arbiter : shares one single-port sync memory between two ports.
// Optional: MEM_ARBITER_RR_EN selects round-robin instead of fixed
// priority with starvation override.
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module mem_arbiter #(
    parameter int WIDTH        = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    mem_arbiter_if.slave    bus
);
    localparam logic [WIDTH-1:0] c_zero = '0;

    logic w_gnt0;
    logic w_gnt1;
    logic r_pending;
    logic r_owner;
    logic w_rvalid0;
    logic w_rvalid1;

`ifdef MEM_ARBITER_RR_EN
    logic r_last;

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst) begin
            if (bus.req0 && bus.req1) begin
                w_gnt0 = r_last;
                w_gnt1 = !r_last;
            end else begin
                w_gnt0 = bus.req0;
                w_gnt1 = bus.req1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last <= 1'b1;
        end else if (w_gnt0) begin
            r_last <= 1'b0;
        end else if (w_gnt1) begin
            r_last <= 1'b1;
        end
    end
`else
    localparam logic [7:0] c_starve_limit = 8'(STARVE_LIMIT);

    logic [7:0] r_starve_cnt;
    logic       w_starved;

    assign w_starved = (r_starve_cnt >= c_starve_limit);

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst) begin
            if (bus.req1 && (w_starved || !bus.req0)) begin
                w_gnt1 = 1'b1;
            end else if (bus.req0) begin
                w_gnt0 = 1'b1;
            end
        end
    end

    // Saturating count of consecutive denied port-1 cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_starve_cnt <= 8'd0;
        end else if (bus.req1 && !w_gnt1) begin
            if (r_starve_cnt != 8'hFF) begin
                r_starve_cnt <= r_starve_cnt + 8'd1;
            end
        end else begin
            r_starve_cnt <= 8'd0;
        end
    end
`endif

    always_comb begin
        bus.mem_addr = bus.addr0;
        bus.mem_in   = c_zero;
        bus.mem_we   = 1'b0;
        if (w_gnt0) begin
            bus.mem_in = bus.wdata0;
            bus.mem_we = bus.we0;
        end else if (w_gnt1) begin
            bus.mem_addr = bus.addr1;
            bus.mem_in   = bus.wdata1;
            bus.mem_we   = bus.we1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pending <= 1'b0;
            r_owner   <= 1'b0;
        end else begin
            r_pending <= w_gnt0 || w_gnt1;
            r_owner   <= w_gnt1;
        end
    end

    // Gating with rst drops a response whose grant preceded a reset edge.
    assign w_rvalid0 = rst && r_pending && !r_owner;
    assign w_rvalid1 = rst && r_pending && r_owner;

    assign bus.gnt0    = w_gnt0;
    assign bus.gnt1    = w_gnt1;
    assign bus.rvalid0 = w_rvalid0;
    assign bus.rvalid1 = w_rvalid1;
    assign bus.rdata0  = w_rvalid0 ? bus.mem_out : c_zero;
    assign bus.rdata1  = w_rvalid1 ? bus.mem_out : c_zero;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//----------------------------------------------------------------------
// tb_mem_arbiter : table-driven bench with response scoreboard.
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;
    typedef struct {
        logic        rst;
        logic        req0;
        logic        we0;
        logic [31:0] addr0;
        logic [31:0] wdata0;
        logic        req1;
        logic        we1;
        logic [31:0] addr1;
        logic [31:0] wdata1;
        logic        g0;
        logic        g1;
    } vec_t;

    typedef struct {
        logic        v0;
        logic        v1;
        logic [31:0] d0;
        logic [31:0] d1;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        loaded = 1'b0;
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    vec_t        tbl [$];
    rsp_t        sbq [$];
    int          checks = 0;
    int          errors = 0;

    mem_arbiter_if #(.WIDTH(32)) bus ();

    mem_arbiter #(.WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 5) return 32'hDEADBEEF;
        if (i == 9) return 32'h0;
        return 32'hA000_0000 | (32'(i) * 32'h0101);
    endfunction

    // Single-port memory: 1-cycle read latency, read-before-write.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            loaded <= 1'b1;
        end else begin
            bus.mem_out <= mem[bus.mem_addr[7:0]];
            if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_in;
        end
    end

    function automatic vec_t mk(input logic r, input logic q0, input logic w0,
                                input logic [31:0] a0, input logic [31:0] d0,
                                input logic q1, input logic w1,
                                input logic [31:0] a1, input logic [31:0] d1,
                                input logic eg0, input logic eg1);
        vec_t v;
        v.rst = r;   v.req0 = q0; v.we0 = w0; v.addr0 = a0; v.wdata0 = d0;
        v.req1 = q1; v.we1 = w1; v.addr1 = a1; v.wdata1 = d1;
        v.g0 = eg0;  v.g1 = eg1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input int idx);
        rsp_t e;
        rsp_t n;
        logic ev0;
        logic ev1;
        rst        = v.rst;
        bus.req0   = v.req0;  bus.we0 = v.we0; bus.addr0 = v.addr0; bus.wdata0 = v.wdata0;
        bus.req1   = v.req1;  bus.we1 = v.we1; bus.addr1 = v.addr1; bus.wdata1 = v.wdata1;
        @(negedge clk);
        chk($sformatf("gnt0[%0d]", idx), 32'(bus.gnt0), 32'(v.g0));
        chk($sformatf("gnt1[%0d]", idx), 32'(bus.gnt1), 32'(v.g1));
        chk($sformatf("mem_we[%0d]", idx), 32'(bus.mem_we),
            32'((v.g0 && v.we0) || (v.g1 && v.we1)));
        chk($sformatf("mem_addr[%0d]", idx), bus.mem_addr, v.g1 ? v.addr1 : v.addr0);
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard[%0d]: got empty queue expected entry", idx);
        end else begin
            e   = sbq.pop_front();
            ev0 = e.v0 && v.rst;
            ev1 = e.v1 && v.rst;
            chk($sformatf("rvalid0[%0d]", idx), 32'(bus.rvalid0), 32'(ev0));
            chk($sformatf("rvalid1[%0d]", idx), 32'(bus.rvalid1), 32'(ev1));
            chk($sformatf("rdata0[%0d]", idx), bus.rdata0, ev0 ? e.d0 : 32'h0);
            chk($sformatf("rdata1[%0d]", idx), bus.rdata1, ev1 ? e.d1 : 32'h0);
        end
        n.v0 = v.g0; n.v1 = v.g1; n.d0 = 32'h0; n.d1 = 32'h0;
        if (v.g0) begin
            n.d0 = ref_mem[v.addr0[7:0]];
            if (v.we0) ref_mem[v.addr0[7:0]] = v.wdata0;
        end else if (v.g1) begin
            n.d1 = ref_mem[v.addr1[7:0]];
            if (v.we1) ref_mem[v.addr1[7:0]] = v.wdata1;
        end
        sbq.push_back(n);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rsp_t none;
        int   idx;
        none.v0 = 1'b0; none.v1 = 1'b0; none.d0 = 32'h0; none.d1 = 32'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        sbq.push_back(none);

        // Reset with requests pending, then basic transfers.
        tbl.push_back(mk(0, 1, 1, 32'd5, 32'h1, 1, 1, 32'd7, 32'h2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'd0, 32'h0, 0, 0, 32'd0, 32'h0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 32'd0, 32'h0, 0, 0, 32'd0, 32'h0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 32'd5, 32'h0, 0, 0, 32'd0, 32'h0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 32'd0, 32'h0, 0, 0, 32'd0, 32'h0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 32'd0, 32'h0, 1, 1, 32'd9, 32'h12345678, 0, 1));
        tbl.push_back(mk(1, 0, 0, 32'd0, 32'h0, 1, 0, 32'd9, 32'h0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 32'd0, 32'h0, 0, 0, 32'd0, 32'h0, 0, 0));
        // Back-to-back reads; upper address bits pass through untouched.
        tbl.push_back(mk(1, 1, 0, 32'd1, 32'h0, 0, 0, 32'd0, 32'h0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 32'h00FF0002, 32'h0, 0, 0, 32'd0, 32'h0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 32'd3, 32'h0, 0, 0, 32'd0, 32'h0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 32'd4, 32'hCAFEF00D, 0, 0, 32'd0, 32'h0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 32'd4, 32'h0, 0, 0, 32'd0, 32'h0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 32'd0, 32'h0, 0, 0, 32'd0, 32'h0, 0, 0));

        idx = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], idx);
            idx++;
        end

        // Reset lands the cycle after a port-1 grant: that response is dropped.
        step(mk(1, 0, 0, 32'd0, 32'h0, 1, 0, 32'd7, 32'h0, 0, 1), idx++);
        step(mk(0, 0, 0, 32'd0, 32'h0, 0, 0, 32'd0, 32'h0, 0, 0), idx++);
        step(mk(1, 0, 0, 32'd0, 32'h0, 0, 0, 32'd0, 32'h0, 0, 0), idx++);
        step(mk(1, 0, 0, 32'd0, 32'h0, 1, 0, 32'd9, 32'h0, 0, 1), idx++);

        // Sustained contention right after reset.
        for (int k = 0; k < 10; k++) begin
            logic eg1;
`ifdef MEM_ARBITER_RR_EN
            eg1 = (k % 2) == 1;
`else
            eg1 = (k % 5) == 4;
`endif
            step(mk(1, 1, 0, 32'd1, 32'h0, 1, 0, 32'd7, 32'h0, !eg1, eg1), idx++);
        end
        step(mk(1, 0, 0, 32'd0, 32'h0, 0, 0, 32'd0, 32'h0, 0, 0), idx++);
        step(mk(1, 0, 0, 32'd0, 32'h0, 0, 0, 32'd0, 32'h0, 0, 0), idx++);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
